// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic AXI-Stream arbiter: strict-priority plus round-robin grant, beat-limit truncation, per-source counters.
// Optional header beat before each packet when AXIS_ARB_HDR_EN is defined.
module axis_pkt_arbiter #(
    parameter int unsigned         NUM_SRC       = 3,
    parameter int unsigned         DATA_WIDTH    = 64,
    parameter int unsigned         MAX_PKT_BEATS = 1024,
    parameter logic [NUM_SRC-1:0]  PRIO_MASK     = NUM_SRC'(3'b001)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic                                clear_counters,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_SRC-1:0]                  s_tvalid,
    input  logic [NUM_SRC-1:0]                  s_tlast,
    output logic [NUM_SRC-1:0]                  s_tready,
    output logic [DATA_WIDTH-1:0]               m_tdata,
    output logic                                m_tvalid,
    output logic                                m_tlast,
    input  logic                                m_tready,
    output logic [2:0]                          m_tdest,
    output logic [NUM_SRC-1:0][31:0]            pkt_count,
    output logic [15:0]                         trunc_count,
    output logic                                trunc_pulse
);

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned BEAT_W  = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_PKT_BEATS - 1);

`ifdef AXIS_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, XFER, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
`endif

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [NUM_SRC-1:0][31:0]    pkt_count_q, pkt_count_d;
    logic [15:0]                 trunc_count_q, trunc_count_d;
    logic                        trunc_pulse_q, trunc_pulse_d;
`ifdef AXIS_ARB_HDR_EN
    logic [NUM_SRC-1:0][15:0]    seq_q, seq_d;
    logic [15:0]                 sel_seq;
`endif

    logic [MAX_SRC-1:0]          req8;
    logic [IDX_W-1:0]            rr_idx;
    logic [IDX_W-1:0]            pick;
    logic                        any_prio;
    logic [NUM_SRC-1:0]          sel_mask;
    logic [DATA_WIDTH-1:0]       sel_data;
    logic                        sel_valid;
    logic                        sel_last;

    // Grant choice: lowest-index priority requester, else first requester after last_grant
    always_comb begin
        req8     = MAX_SRC'(s_tvalid);
        pick     = '0;
        rr_idx   = '0;
        any_prio = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (s_tvalid[i] && PRIO_MASK[i]) begin
                pick     = IDX_W'(i);
                any_prio = 1'b1;
            end
        end
        if (!any_prio) begin
            for (int k = int'(NUM_SRC); k >= 1; k--) begin
                rr_idx = IDX_W'((int'(last_grant_q) + k) % int'(NUM_SRC));
                if (req8[rr_idx]) pick = rr_idx;
            end
        end
    end

    // Granted-source mux
    always_comb begin
        sel_mask  = '0;
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
`ifdef AXIS_ARB_HDR_EN
        sel_seq   = '0;
`endif
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_mask[i] = 1'b1;
                sel_data    = s_tdata[i];
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
`ifdef AXIS_ARB_HDR_EN
                sel_seq     = seq_q[i];
`endif
            end
        end
    end

    // Next-state and combinational stream outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_d        = beat_q;
        pkt_count_d   = pkt_count_q;
        trunc_count_d = trunc_count_q;
        trunc_pulse_d = 1'b0;
`ifdef AXIS_ARB_HDR_EN
        seq_d         = seq_q;
`endif
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        m_tdata       = '0;
        s_tready      = '0;

        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (ena && (|s_tvalid)) begin
                    grant_d = pick;
                    if (!any_prio) last_grant_d = pick;
`ifdef AXIS_ARB_HDR_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef AXIS_ARB_HDR_EN
            HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = DATA_WIDTH'({8'hA5, 8'(grant_q), sel_seq, 32'h0});
                if (m_tready) begin
                    for (int i = 0; i < int'(NUM_SRC); i++) begin
                        if (sel_mask[i]) seq_d[i] = seq_q[i] + 16'd1;
                    end
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                m_tvalid = sel_valid;
                m_tdata  = sel_data;
                m_tlast  = sel_last || (beat_q == LAST_BEAT);
                s_tready = sel_mask & {NUM_SRC{m_tready}};
                if (sel_valid && m_tready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (sel_last) begin
                        state_d = IDLE;
                        for (int i = 0; i < int'(NUM_SRC); i++) begin
                            if (sel_mask[i] && (pkt_count_q[i] != 32'hFFFF_FFFF))
                                pkt_count_d[i] = pkt_count_q[i] + 32'd1;
                        end
                    end else if (beat_q == LAST_BEAT) begin
                        state_d       = DRAIN;
                        trunc_pulse_d = 1'b1;
                        if (trunc_count_q != 16'hFFFF) trunc_count_d = trunc_count_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                s_tready = sel_mask;
                if (sel_valid && sel_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear takes precedence over any same-cycle increment
        if (clear_counters) begin
            pkt_count_d   = '0;
            trunc_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_SRC - 1);
            beat_q        <= '0;
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
            trunc_pulse_q <= 1'b0;
`ifdef AXIS_ARB_HDR_EN
            seq_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_q        <= beat_d;
            pkt_count_q   <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
            trunc_pulse_q <= trunc_pulse_d;
`ifdef AXIS_ARB_HDR_EN
            seq_q         <= seq_d;
`endif
        end
    end

    assign m_tdest     = grant_q;
    assign pkt_count   = pkt_count_q;
    assign trunc_count = trunc_count_q;
    assign trunc_pulse = trunc_pulse_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: queued source drivers, expected-beat queue, decoupled output monitor.
module tb_axis_pkt_arbiter;

    localparam int unsigned NS   = 3;
    localparam int unsigned DW   = 64;
    localparam int unsigned MAXB = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ena;
    logic                     clear_counters;
    logic [NS-1:0][DW-1:0]    s_tdata;
    logic [NS-1:0]            s_tvalid;
    logic [NS-1:0]            s_tlast;
    logic [NS-1:0]            s_tready;
    logic [DW-1:0]            m_tdata;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;
    logic [2:0]               m_tdest;
    logic [NS-1:0][31:0]      pkt_count;
    logic [15:0]              trunc_count;
    logic                     trunc_pulse;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [2:0]    dest;
        logic [DW-1:0] data;
        logic          last;
        int            abs_win;
        int            gap;
    } exp_t;

    beat_t       src_q[NS][$];
    exp_t        exp_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          pulse_cnt = 0;
    int          prev_win  = -100;
    bit          rdy_rand  = 1'b0;
    bit [NS-1:0] hs_pend;

    axis_pkt_arbiter #(
        .NUM_SRC       (NS),
        .DATA_WIDTH    (DW),
        .MAX_PKT_BEATS (MAXB),
        .PRIO_MASK     (3'b001)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .clear_counters (clear_counters),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .m_tdest        (m_tdest),
        .pkt_count      (pkt_count),
        .trunc_count    (trunc_count),
        .trunc_pulse    (trunc_pulse)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [DW-1:0] mk(int s, int id, int b);
        return {16'hBEEF, 8'(s), 8'(id), 32'(b)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_pkt(int src, int id, int n);
        for (int b = 1; b <= n; b++) begin
            beat_t x;
            x.data = mk(src, id, b);
            x.last = (b == n);
            src_q[src].push_back(x);
        end
    endtask

    // n_out beats expected; strict=1 pins first-beat window/gap and later gaps to 1
    task automatic exp_pkt(int src, int id, int n_out, int abs_first, int gap_first,
                           bit strict, bit with_last);
        for (int b = 1; b <= n_out; b++) begin
            exp_t e;
            e.dest    = 3'(src);
            e.data    = mk(src, id, b);
            e.last    = with_last && (b == n_out);
            e.abs_win = (strict && b == 1) ? abs_first : -1;
            e.gap     = !strict ? 0 : ((b == 1) ? gap_first : 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(string name, bit [NS-1:0] mask, int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0);
            for (int i = 0; i < int'(NS); i++)
                if (mask[i] && src_q[i].size() != 0) done = 1'b0;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Source drivers: present queue heads at negedge, retire beats that handshook
    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        hs_pend  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < int'(NS); i++)
                if (hs_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < int'(NS); i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = src_q[i][0].data;
                    s_tlast[i]  = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[i]  = '0;
                    s_tlast[i]  = 1'b0;
                end
            end
            #1;
            hs_pend = s_tvalid & s_tready;
        end
    end

    // Output monitor: pops one expectation per output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (trunc_pulse) pulse_cnt++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual dest=%0d data=%0h required no beat",
                             m_tdest, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_dest", 64'(m_tdest), 64'(e.dest));
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_last", 64'(m_tlast), 64'(e.last));
                    if (e.abs_win >= 0) chk("beat_win", 64'(cyc), 64'(e.abs_win));
                    if (e.gap > 0) chk("beat_gap", 64'(cyc - prev_win), 64'(e.gap));
                end
                prev_win = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst            = 1'b1;
        ena            = 1'b1;
        clear_counters = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid",    64'(m_tvalid),    64'd0);
        chk("rst_s_tready",    64'(s_tready),    64'd0);
        chk("rst_m_tdest",     64'(m_tdest),     64'd0);
        chk("rst_pkt_count",   64'(pkt_count),   64'd0);
        chk("rst_trunc_count", 64'(trunc_count), 64'd0);
        chk("rst_trunc_pulse", 64'(trunc_pulse), 64'd0);
        rst = 1'b0;

        // Round-robin between src1 and src2: 1,2,1,2,1,2 with one bubble between packets
        @(posedge clk); #1; w = cyc;
        for (int p = 1; p <= 3; p++) begin
            push_pkt(1, p, 2);
            push_pkt(2, p, 2);
        end
        exp_pkt(1, 1, 2, w + 1, 0, 1'b1, 1'b1);
        exp_pkt(2, 1, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(1, 2, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(2, 2, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(1, 3, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(2, 3, 2, -1, 2, 1'b1, 1'b1);
        wait_done("rr", 3'b110, 200);
        chk("rr_pkt_count1", 64'(pkt_count[1]), 64'd3);
        chk("rr_pkt_count2", 64'(pkt_count[2]), 64'd3);

        // Lone src1 4-beat packet: first beat one cycle after tvalid
        @(posedge clk); #1; w = cyc;
        push_pkt(1, 4, 4);
        exp_pkt(1, 4, 4, w + 1, 0, 1'b1, 1'b1);
        wait_done("single", 3'b010, 100);
        chk("single_pkt_count1", 64'(pkt_count[1]), 64'd4);

        // Priority src0 beats src2 while it keeps requesting
        @(posedge clk); #1; w = cyc;
        for (int p = 1; p <= 3; p++) push_pkt(0, p, 2);
        push_pkt(2, 4, 2);
        exp_pkt(0, 1, 2, w + 1, 0, 1'b1, 1'b1);
        exp_pkt(0, 2, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(0, 3, 2, -1, 2, 1'b1, 1'b1);
        exp_pkt(2, 4, 2, -1, 2, 1'b1, 1'b1);
        wait_done("prio", 3'b101, 200);
        chk("prio_pkt_count0", 64'(pkt_count[0]), 64'd3);
        chk("prio_pkt_count2", 64'(pkt_count[2]), 64'd4);

        // Runaway 20-beat packet: truncated at beat 16, remainder drained silently
        pulse_cnt = 0;
        @(posedge clk); #1; w = cyc;
        push_pkt(2, 5, 20);
        exp_pkt(2, 5, int'(MAXB), w + 1, 0, 1'b1, 1'b1);
        wait_done("trunc", 3'b100, 200);
        chk("trunc_pulse_cnt",   64'(pulse_cnt),     64'd1);
        chk("trunc_count",       64'(trunc_count),   64'd1);
        chk("trunc_pkt_count2",  64'(pkt_count[2]),  64'd4);
        @(posedge clk); #1;
        push_pkt(1, 5, 2);
        exp_pkt(1, 5, 2, -1, 0, 1'b0, 1'b1);
        wait_done("post_trunc", 3'b010, 100);
        chk("post_trunc_pkt_count1", 64'(pkt_count[1]), 64'd5);

        // 16-beat packet at exactly the limit, random backpressure, ena dropped mid-packet
        rdy_rand = 1'b1;
        @(posedge clk); #1;
        push_pkt(1, 6, int'(MAXB));
        exp_pkt(1, 6, int'(MAXB), -1, 0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        ena = 1'b0;
        push_pkt(2, 7, 2);
        wait_done("ena_off", 3'b010, 300);
        rdy_rand = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ena_off_src2_pending", 64'(src_q[2].size()), 64'd2);
        chk("ena_off_m_tvalid",     64'(m_tvalid),        64'd0);
        chk("ena_off_pkt_count1",   64'(pkt_count[1]),    64'd6);
        chk("limit_trunc_count",    64'(trunc_count),     64'd1);
        w = cyc;
        ena = 1'b1;
        exp_pkt(2, 7, 2, w + 1, 0, 1'b1, 1'b1);
        wait_done("ena_on", 3'b100, 100);
        chk("ena_on_pkt_count2", 64'(pkt_count[2]), 64'd5);

        // Clear in the same cycle as a packet-complete increment: clear wins
        @(posedge clk); #1; w = cyc;
        push_pkt(0, 9, 1);
        exp_pkt(0, 9, 1, w + 1, 0, 1'b1, 1'b1);
        @(posedge clk); #1;
        clear_counters = 1'b1;
        @(posedge clk); #1;
        clear_counters = 1'b0;
        wait_done("clear", 3'b001, 100);
        chk("clear_pkt_count",   64'(pkt_count),   64'd0);
        chk("clear_trunc_count", 64'(trunc_count), 64'd0);

        // Reset mid-packet: three beats delivered, then everything returns to reset values
        @(posedge clk); #1; w = cyc;
        push_pkt(1, 10, 8);
        exp_pkt(1, 10, 3, w + 1, 0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        chk("midrst_m_tdest",  64'(m_tdest),  64'd0);
        src_q[1].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("midrst", 3'b111, 50);
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
